weighted_rr_arbiter: RTL



---
 rtl/weighted_rr_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/weighted_rr_arbiter.sv
// Registered weighted round-robin arbiter: one owner at a time, each held for a programmable quantum.
// Define ARB_LOCK_EN to let the owner's locks bit stretch its grant past the quantum.
module weighted_rr_arbiter #(
    parameter  int NUM_CLIENTS = 8,
    parameter  int WEIGHT_W    = 4,
    localparam int SEL_W       = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_CLIENTS-1:0]          requests,
    input  logic [NUM_CLIENTS*WEIGHT_W-1:0] weights,
    input  logic [NUM_CLIENTS-1:0]          locks,
    output logic [NUM_CLIENTS-1:0]          grants,
    output logic [SEL_W-1:0]                grant_idx,
    output logic                            grant_valid
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                 stateQ, stateD;
    logic [NUM_CLIENTS-1:0] grantsQ, grantsD;
    logic [SEL_W-1:0]       idxQ, idxD;
    logic [SEL_W-1:0]       lastQ, lastD;
    logic [WEIGHT_W-1:0]    cntQ, cntD;
    logic                   validQ, validD;

    // Search starts just after the last owner and wraps, so the last owner is tried last.
    function automatic logic [SEL_W:0] pickNext(input logic [NUM_CLIENTS-1:0] mask,
                                                input logic [SEL_W-1:0]       last);
        int               idx;
        logic             found;
        logic [SEL_W-1:0] sel;
        found = 1'b0;
        sel   = '0;
        for (int k = 1; k <= NUM_CLIENTS; k++) begin
            idx = int'(last) + k;
            if (idx >= NUM_CLIENTS) idx = idx - NUM_CLIENTS;
            if (!found && mask[idx]) begin
                found = 1'b1;
                sel   = SEL_W'(idx);
            end
        end
        return {found, sel};
    endfunction

    function automatic logic [WEIGHT_W-1:0] effWeight(input logic [SEL_W-1:0] sel,
                                                     input logic [NUM_CLIENTS*WEIGHT_W-1:0] w);
        logic [WEIGHT_W-1:0] raw;
        raw = w[int'(sel)*WEIGHT_W +: WEIGHT_W];
        return (raw == '0) ? WEIGHT_W'(1) : raw;
    endfunction

    logic                   ownerReq, ownerLock;
    logic [NUM_CLIENTS-1:0] ownerMask;
    logic [SEL_W:0]         pickAll, pickOthers;
    logic                   loadEn;
    logic [SEL_W-1:0]       loadIdx;

    always_comb begin
        ownerMask          = '0;
        ownerMask[idxQ]    = 1'b1;
        ownerReq           = requests[idxQ];
        pickAll            = pickNext(requests, lastQ);
        pickOthers         = pickNext(requests & ~ownerMask, lastQ);
    end

`ifdef ARB_LOCK_EN
    assign ownerLock = locks[idxQ];
`else
    logic unusedLocks;
    assign unusedLocks = ^locks;
    assign ownerLock   = 1'b0;
`endif

    always_comb begin
        stateD  = stateQ;
        grantsD = grantsQ;
        idxD    = idxQ;
        lastD   = lastQ;
        cntD    = cntQ;
        validD  = validQ;
        loadEn  = 1'b0;
        loadIdx = idxQ;

        case (stateQ)
            IDLE: begin
                if (pickAll[SEL_W]) begin
                    loadEn  = 1'b1;
                    loadIdx = pickAll[SEL_W-1:0];
                end
            end
            GRANT: begin
                if (!ownerReq) begin
                    if (pickOthers[SEL_W]) begin
                        loadEn  = 1'b1;
                        loadIdx = pickOthers[SEL_W-1:0];
                    end else begin
                        stateD  = IDLE;
                        grantsD = '0;
                        validD  = 1'b0;
                        cntD    = '0;
                    end
                end else if (cntQ > WEIGHT_W'(1)) begin
                    cntD = cntQ - WEIGHT_W'(1);
                end else if (ownerLock) begin
                    cntD = WEIGHT_W'(1);
                end else if (pickOthers[SEL_W]) begin
                    loadEn  = 1'b1;
                    loadIdx = pickOthers[SEL_W-1:0];
                end else begin
                    // Nobody else is waiting: the owner keeps the resource with a fresh quantum.
                    loadEn  = 1'b1;
                    loadIdx = idxQ;
                end
            end
            default: begin
                stateD = IDLE;
            end
        endcase

        if (loadEn) begin
            stateD           = GRANT;
            grantsD          = '0;
            grantsD[loadIdx] = 1'b1;
            idxD             = loadIdx;
            lastD            = loadIdx;
            cntD             = effWeight(loadIdx, weights);
            validD           = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ  <= IDLE;
            grantsQ <= '0;
            idxQ    <= '0;
            lastQ   <= SEL_W'(NUM_CLIENTS - 1);
            cntQ    <= '0;
            validQ  <= 1'b0;
        end else begin
            stateQ  <= stateD;
            grantsQ <= grantsD;
            idxQ    <= idxD;
            lastQ   <= lastD;
            cntQ    <= cntD;
            validQ  <= validD;
        end
    end

    assign grants      = grantsQ;
    assign grant_idx   = idxQ;
    assign grant_valid = validQ;

endmodule
